// File: rtl/db9md_pkg.sv
// Shared types and constants for the DB9 Mega Drive scan sequencer.
package db9md_pkg;

  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  typedef enum logic [1:0] {NONE, SMS, MD3, MD6} pad_type_t;

  typedef enum logic [3:0] {
    IDLE, SETTLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, COMMIT
  } scan_state_t;

  // Select level per phase, bit n = PHn: H,L,H,L,H,L,H,L
  localparam logic [7:0] MDSEL_PHASE = 8'b01010101;

  typedef struct packed {
    logic [11:0] btn;
    logic        md;
    logic        six;
  } shadow_t;

endpackage

// File: rtl/db9md_tick.sv
// Protocol tick divider; restart zeroes the phase so every state gets full ticks.
module db9md_tick #(
  parameter int TICK_DIV = 400
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || restart || tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/db9md_scan_ctrl.sv
// Serial SNAC DB9 Mega Drive scan sequencer: time-shares the pins between two
// pads, runs the select-line protocol and commits decoded 12-bit button words.
module db9md_scan_ctrl
  import db9md_pkg::*;
#(
  parameter int TICK_DIV   = 400,
  parameter int IDLE_TICKS = 200,
  parameter int TWO_PORTS  = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic [1:0]  pad_type1,
  output logic [1:0]  pad_type2,
  output logic        scan_done
);
  localparam int IW = $clog2(IDLE_TICKS + 1);

  logic [5:0]  sync1, sync2, p;
  logic [1:0]  en_pipe;
  logic        run, tick, restart, port_q, is_ph;
  logic [2:0]  ph;
  logic [IW-1:0] idle_q;
  scan_state_t st_q, st_d;
  shadow_t     sh_q;
  logic [11:0] commit_btn;
  pad_type_t   commit_type;

  // A scan may only start once enable has been seen for two cycles;
  // dropping it aborts on the very next edge.
  assign run = enable & en_pipe[1];
  assign p   = ~sync2;

  db9md_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign is_ph     = (st_q >= PH0) && (st_q <= PH7);
  assign ph        = 3'(st_q - PH0);
  assign joy_mdsel = is_ph ? MDSEL_PHASE[ph] : 1'b1;
  assign joy_split = port_q;
  assign restart   = (st_d != st_q) || !run;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (tick && idle_q == IW'(IDLE_TICKS - 1)) st_d = SETTLE;
      SETTLE:  if (tick) st_d = PH0;
      PH7:     if (tick) st_d = COMMIT;
      COMMIT:  st_d = (TWO_PORTS != 0 && !port_q) ? SETTLE : IDLE;
      default: if (tick) st_d = scan_state_t'(st_q + 4'd1);
    endcase
    if (!run) st_d = IDLE;
  end

  always_comb begin
    commit_btn  = sh_q.btn;
    commit_type = MD6;
    if (!sh_q.md) begin
      commit_type           = SMS;
      commit_btn[BTN_A]     = 1'b0;
      commit_btn[BTN_START] = 1'b0;
      commit_btn[BTN_MODE]  = 1'b0;
      commit_btn[BTN_X]     = 1'b0;
      commit_btn[BTN_Y]     = 1'b0;
      commit_btn[BTN_Z]     = 1'b0;
    end else if (!sh_q.six) begin
      commit_type           = MD3;
      commit_btn[BTN_MODE]  = 1'b0;
      commit_btn[BTN_X]     = 1'b0;
      commit_btn[BTN_Y]     = 1'b0;
      commit_btn[BTN_Z]     = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1   <= '1;
      sync2   <= '1;
      en_pipe <= '0;
    end else begin
      sync1   <= joy_in;
      sync2   <= sync1;
      en_pipe <= {en_pipe[0], enable};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || !run) begin
      st_q      <= IDLE;
      port_q    <= 1'b0;
      idle_q    <= '0;
      sh_q      <= '0;
      joystick1 <= '0;
      joystick2 <= '0;
      pad_type1 <= NONE;
      pad_type2 <= NONE;
      scan_done <= 1'b0;
    end else begin
      st_q      <= st_d;
      scan_done <= 1'b0;
      if (st_q == IDLE && tick)
        idle_q <= (st_d == SETTLE) ? '0 : idle_q + IW'(1);
      // Pad output is sampled on the last cycle of each phase
      if (tick) begin
        case (st_q)
          PH0: begin
            sh_q.btn[BTN_U] <= p[0];
            sh_q.btn[BTN_D] <= p[1];
            sh_q.btn[BTN_L] <= p[2];
            sh_q.btn[BTN_R] <= p[3];
            sh_q.btn[BTN_B] <= p[4];
            sh_q.btn[BTN_C] <= p[5];
          end
          PH1: begin
            sh_q.btn[BTN_A]     <= p[4];
            sh_q.btn[BTN_START] <= p[5];
            sh_q.md             <= p[2] & p[3];
          end
          PH5: sh_q.six <= &p[3:0];
          PH6: begin
            sh_q.btn[BTN_Z]    <= p[0];
            sh_q.btn[BTN_Y]    <= p[1];
            sh_q.btn[BTN_X]    <= p[2];
            sh_q.btn[BTN_MODE] <= p[3];
          end
          default: ;
        endcase
      end
      if (st_q == COMMIT) begin
        if (port_q) begin
          joystick2 <= commit_btn;
          pad_type2 <= commit_type;
        end else begin
          joystick1 <= commit_btn;
          pad_type1 <= commit_type;
        end
        port_q    <= (st_d == SETTLE);
        scan_done <= (st_d == IDLE);
      end
    end
  end
endmodule

// File: tb/tb_db9md_scan_ctrl.sv
// Directed bench: pad models on both ports, abort/restart timing, single-port variant.
module tb_db9md_scan_ctrl;
  import db9md_pkg::*;

  localparam int T     = 8;
  localparam int IDLE  = 4;
  localparam int FRAME = (18 + IDLE) * T + 2;

  logic        clk_sys, reset, enable;
  logic [5:0]  joy_in;
  logic        joy_split, joy_mdsel, scan_done;
  logic [11:0] joystick1, joystick2;
  logic [1:0]  pad_type1, pad_type2;

  logic        rst_b, en_b;
  logic [5:0]  joy_in_b;
  logic        split_b, mdsel_b, sd_b;
  logic [11:0] j1_b, j2_b;
  logic [1:0]  pt1_b, pt2_b;

  int total = 0, bad = 0;
  int cyc = 0;
  int type1, type2;
  logic [11:0] btn1, btn2;

  db9md_scan_ctrl #(.TICK_DIV(T), .IDLE_TICKS(IDLE), .TWO_PORTS(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .joy_in(joy_in),
    .joy_split(joy_split), .joy_mdsel(joy_mdsel),
    .joystick1(joystick1), .joystick2(joystick2),
    .pad_type1(pad_type1), .pad_type2(pad_type2), .scan_done(scan_done));

  db9md_scan_ctrl #(.TICK_DIV(4), .IDLE_TICKS(2), .TWO_PORTS(0)) dut_b (
    .clk_sys(clk_sys), .reset(rst_b), .enable(en_b), .joy_in(joy_in_b),
    .joy_split(split_b), .joy_mdsel(mdsel_b),
    .joystick1(j1_b), .joystick2(j2_b),
    .pad_type1(pt1_b), .pad_type2(pt2_b), .scan_done(sd_b));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  // Pad pins (active-low) for a pad type, held buttons, select level and select-fall count
  function automatic logic [5:0] pad_pins(input int ty, input logic [11:0] b,
                                          input logic sel, input int f);
    logic [5:0] h;
    logic [5:0] nrm, low;
    nrm = {b[BTN_C], b[BTN_B], b[BTN_R], b[BTN_L], b[BTN_D], b[BTN_U]};
    low = {b[BTN_START], b[BTN_A], 2'b11, b[BTN_D], b[BTN_U]};
    case (ty)
      1:       h = nrm;
      2:       h = sel ? nrm : low;
      3:       if (sel) h = (f == 3) ? {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]} : nrm;
               else     h = (f == 3) ? {b[BTN_START], b[BTN_A], 4'hF} : low;
      default: h = 6'h00;
    endcase
    return ~h;
  endfunction

  int f = 0, hi_run = 0;
  logic last_sel = 1'b1, last_split = 1'b0;
  always @(negedge clk_sys) begin
    if (joy_split != last_split)      f = 0;
    else if (last_sel && !joy_mdsel)  f = f + 1;
    else if (hi_run > 2 * T + 2)      f = 0;
    hi_run     = joy_mdsel ? hi_run + 1 : 0;
    last_sel   = joy_mdsel;
    last_split = joy_split;
    joy_in     = pad_pins(joy_split ? type2 : type1, joy_split ? btn2 : btn1, joy_mdsel, f);
  end

  int nb = 0, last_b = 0, prev_b = 0;
  bit split_b_seen = 0;
  always @(negedge clk_sys) begin
    if (split_b) split_b_seen = 1;
    if (sd_b) begin
      prev_b = last_b;
      last_b = cyc;
      nb++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_j1"},    32'(joystick1), 0);
    chk({tag, "_j2"},    32'(joystick2), 0);
    chk({tag, "_pt1"},   32'(pad_type1), 0);
    chk({tag, "_pt2"},   32'(pad_type2), 0);
    chk({tag, "_split"}, 32'(joy_split), 0);
    chk({tag, "_mdsel"}, 32'(joy_mdsel), 1);
    chk({tag, "_done"},  32'(scan_done), 0);
  endtask

  // Returns negedge count until scan_done is seen, or -1 on timeout
  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk_sys);
      if (scan_done) begin
        n = i;
        break;
      end
    end
  endtask

  int n, pulses;

  initial begin
    reset = 1'b1; enable = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; joy_in_b = 6'h3F;
    type1 = 3; btn1 = 12'h880;
    type2 = 3; btn2 = 12'h240;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0; rst_b = 1'b0;
    @(negedge clk_sys);
    chk_rst("reset");

    // Two 6-button pads
    enable = 1'b1;
    wait_done(600, n);
    chk("md6_timeout", 32'(n > 0), 1);
    chk("md6_j1",  32'(joystick1), 32'h880);
    chk("md6_pt1", 32'(pad_type1), 3);
    chk("md6_j2",  32'(joystick2), 32'h240);
    chk("md6_pt2", 32'(pad_type2), 3);
    wait_done(400, n);
    chk("frame_period", 32'(n), 32'(FRAME));
    @(negedge clk_sys);
    chk("done_one_cycle", 32'(scan_done), 0);

    // 3-button pad, Mode ignored by the pad
    type1 = 2; btn1 = (12'd1 << BTN_MODE) | (12'd1 << BTN_C);
    wait_done(400, n);
    chk("md3_timeout", 32'(n > 0), 1);
    chk("md3_j1",  32'(joystick1), 32'h020);
    chk("md3_pt1", 32'(pad_type1), 2);
    chk("md3_j2",  32'(joystick2), 32'h240);

    // SMS pad: L/R never forced low
    type1 = 1; btn1 = (12'd1 << BTN_U) | (12'd1 << BTN_B);
    wait_done(400, n);
    chk("sms_j1",  32'(joystick1), 32'h018);
    chk("sms_pt1", 32'(pad_type1), 1);

    // Drop enable during PH3 of port 2
    n = 0;
    for (int i = 0; i < 400 && !joy_split; i++) @(negedge clk_sys);
    chk("port2_seen", 32'(joy_split), 1);
    repeat (4 * T + 2) @(negedge clk_sys);
    chk("ph3_mdsel", 32'(joy_mdsel), 0);
    enable = 1'b0;
    @(negedge clk_sys);
    chk_rst("disable");
    repeat (3) @(negedge clk_sys);
    enable = 1'b1;
    wait_done(400, n);
    chk("reenable_latency", 32'(n), 32'(FRAME + 2));
    chk("reenable_j1", 32'(joystick1), 32'h018);

    // Reset during PH6 of port 1
    for (int i = 0; i < 400 && joy_mdsel; i++) @(negedge clk_sys);
    chk("p1_ph1_split", 32'(joy_split), 0);
    repeat (5 * T + 1) @(negedge clk_sys);
    chk("ph6_mdsel", 32'(joy_mdsel), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk_rst("midreset");
    @(negedge clk_sys);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_sys);
      if (scan_done) pulses++;
    end
    chk("no_done_after_reset", 32'(pulses), 0);
    wait_done(400, n);
    chk("after_reset_j1", 32'(joystick1), 32'h018);
    chk("after_reset_j2", 32'(joystick2), 32'h240);

    // Single-port instance, TICK_DIV=4, IDLE_TICKS=2
    chk("b_pulses", 32'(nb >= 2), 1);
    chk("b_period", 32'(last_b - prev_b), 45);
    chk("b_split_never", 32'(split_b_seen), 0);
    chk("b_j2",  32'(j2_b), 0);
    chk("b_pt2", 32'(pt2_b), 0);
    chk("b_pt1", 32'(pt1_b), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/db9md_scan_ctrl.md
# db9md_scan_ctrl

Scan sequencer for the Serial SNAC DB9 Mega Drive port. It time-shares the six active-low USER_IN joystick lines between player 1 and player 2 by driving `joy_split`. For each port it runs the Mega Drive select-line protocol on `joy_mdsel` and decodes the result into active-high 12-bit button words. It sits between the user-port pins and the core's `joystick_0`/`joystick_1` muxing, and runs in the `clk_sys` (40 MHz) domain.

## Interface
- `TICK_DIV`, default 400: `clk_sys` cycles per protocol tick (10 µs at 40 MHz); minimum 4.
- `IDLE_TICKS`, default 200: idle ticks after a full scan, so the pad's internal phase counter resets (≥1.6 ms).
- `TWO_PORTS`, default 1: set to 0 to skip the port-2 scan.
- `clk_sys`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `enable`  in  1  SNAC mode on, i.e. `|status[31:30]`.
- `joy_in`  in  6  raw active-low pins: [0] up, [1] down, [2] left, [3] right, [4] B/A, [5] C/Start.
- `joy_split`  out  1  port select; 0 = port 1, 1 = port 2.
- `joy_mdsel`  out  1  Mega Drive select line.
- `joystick1`, `joystick2`  out  12 each  active-high: [0] R, [1] L, [2] D, [3] U, [4] B, [5] C, [6] A, [7] Start, [8] Mode, [9] X, [10] Y, [11] Z.
- `pad_type1`, `pad_type2`  out  2 each  0 none/disabled, 1 SMS/Atari, 2 MD 3-button, 3 MD 6-button.
- `scan_done`  out  1  one-cycle pulse after both ports are committed.

## Operation
- `joy_in` passes through a 2-flop synchronizer. All decode uses the synchronized, inverted value `p`, which is active-high.
- State machine: IDLE -> SETTLE -> PH0..PH7 -> COMMIT -> (SETTLE for port 2, or IDLE).
  - IDLE counts `IDLE_TICKS` ticks.
  - SETTLE drives `joy_split` and holds `joy_mdsel`=1 for 1 tick.
  - Each PHn lasts 1 tick.
  - COMMIT lasts 1 cycle.
- `joy_mdsel` per phase is H, L, H, L, H, L, H, L for PH0..PH7. It is set on phase entry and returns to 1 in COMMIT.
- Sampling happens on the last cycle of each phase, into a per-scan shadow register:
  - PH0: U, D, L, R, B, C from p[3:0], p[4], p[5].
  - PH1: A = p[4], Start = p[5]. `md` = p[2] & p[3] (L and R both forced low).
  - PH5: `six` = p[3:0] == 4'hF.
  - PH6: Z = p[0], Y = p[1], X = p[2], Mode = p[3].
  - PH2, PH3, PH4, PH7: no sample.
- COMMIT copies the shadow to the addressed port's outputs atomically:
  - If `md`=0: type 1; A, Start, Mode, X, Y, Z forced 0.
  - If `md`=1, `six`=0: type 2; Mode, X, Y, Z forced 0.
  - Otherwise: type 3.
- After port 1 commits, port 2 is scanned (if `TWO_PORTS`=1). `scan_done` pulses on the final COMMIT, then the FSM enters IDLE.
- With `TWO_PORTS`=0, `joystick2` and `pad_type2` hold 0.
- `enable`=0 at any point: FSM goes to IDLE with its idle counter cleared; all outputs return to reset values on the next edge; the shadow is discarded.
- When `enable` rises, scanning starts after one full IDLE period.

## Timing
- Reset values: `joy_split`=0, `joy_mdsel`=1, `joystick1`/`joystick2`=0, `pad_type1`/`pad_type2`=0, `scan_done`=0. FSM is in IDLE with the tick and idle counters at 0.
- Tick generator: a free-running counter from 0 to `TICK_DIV`-1. It restarts at 0 on every state transition, so each phase is exactly `TICK_DIV` cycles.
- Per port: 9 ticks + 1 cycle. A full frame is (2×9 + `IDLE_TICKS`) ticks + 2 cycles; with defaults that is 87,202 cycles.
- Pin-to-output latency: 2 synchronizer cycles + the remainder of the phase + COMMIT. A pin change is visible no later than one frame + 2 cycles after it occurs.
- Outputs change only in the COMMIT cycle (registered, one cycle after COMMIT entry) or on reset/disable.
- Reset or `enable` fall mid-phase: abort takes effect on that edge; no partial commit.

## Structure
- Package `db9md_pkg` holds:
  - button bit-index localparams (BTN_R..BTN_Z);
  - `pad_type_t` (NONE, SMS, MD3, MD6);
  - `scan_state_t` (IDLE, SETTLE, PH0..PH7, COMMIT);
  - the per-phase `joy_mdsel` constant vector 8'b01010101, indexed by phase.
- One sub-module, `db9md_tick`: the `TICK_DIV` counter with a synchronous `restart` input and a `tick` output pulse.

## Test plan
- 6-button pad model on both ports, port 1 holding Z + Start, port 2 holding X + A, `enable`=1:
  - after the first `scan_done`: `joystick1` = 12'h880, `pad_type1`=3, `joystick2` = 12'h240, `pad_type2`=3.
- 3-button model on port 1, Mode pressed (ignored by the pad), C held:
  - `joystick1` = 12'h020, `pad_type1`=2.
- SMS model (L/R never forced low), up + button 1 on port 1:
  - `joystick1` = 12'h018, `pad_type1`=1.
- Drop `enable` during PH3 of port 2:
  - next edge: all outputs 0, `joy_mdsel`=1, `joy_split`=0.
  - re-enable: first `scan_done` at exactly one frame + 2 cycles after the rise.
- Assert `reset` during PH6 of port 1:
  - all outputs are at reset values on the next edge; no `scan_done` for that frame.
- `TWO_PORTS`=0, `TICK_DIV`=4, `IDLE_TICKS`=2:
  - `joy_split` is never 1; `scan_done` period is 11 × 4 + 1 = 45 cycles.
